muldiv_unit: RTL

// - Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
// - Takes operands from the register file read ports (rd1 -> srca, rd2 -> srcb).
// - Executes MULT/MULTU/DIV/DIVU over WIDTH cycles and holds results in HI/LO,

---
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: command/result bundle between the controller and the
// multiply/divide unit.
//   start, op, srca, srcb, mthi, mtlo : controller -> unit
//   busy, done, hi, lo                : unit -> controller
// Modports: master (controller side), slave (muldiv_unit side).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;      // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation in flight
//   bus   : muldiv_unit_if.slave (start/op/srca/srcb/mthi/mtlo in,
//           busy/done/hi/lo out)
// One shift-add (multiply) or restoring (divide) step per RUN cycle on
// operand magnitudes; signs are fixed up when HI/LO are written.
// Optional feature: define MULDIV_FAST_ZERO_EN to let a multiply by zero or
// a divide by zero bypass RUN and finish in one cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;      // partial product high half / partial remainder
    logic [WIDTH-1:0] q;        // multiplier shifting out / dividend->quotient
    logic [WIDTH-1:0] dvs;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0] a_raw;    // dividend as latched, returned in HI on /0
    logic             is_div, neg_q, neg_r, dz;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    // Launch-side operand conditioning
    logic             sa, sb, fz;
    logic [WIDTH-1:0] abs_a, abs_b, fz_hi, fz_lo;

    always_comb begin
        sa    = ~bus.op[0] & bus.srca[WIDTH-1];
        sb    = ~bus.op[0] & bus.srcb[WIDTH-1];
        abs_a = sa ? -bus.srca : bus.srca;
        abs_b = sb ? -bus.srcb : bus.srcb;
        // Zero-operand results match what the iterative path would produce.
        fz_hi = bus.op[1] ? bus.srca : '0;
        fz_lo = bus.op[1] ? '1 : '0;
`ifdef MULDIV_FAST_ZERO_EN
        fz    = bus.op[1] ? (bus.srcb == '0)
                          : ((bus.srca == '0) || (bus.srcb == '0));
`else
        fz    = 1'b0;
`endif
    end

    // One iteration of the shared datapath
    logic [WIDTH:0]     msum, rsh, rdiff;
    logic               qbit;
    logic [WIDTH-1:0]   acc_n, q_n, quo, rem, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        msum  = {1'b0, acc} + (q[0] ? {1'b0, dvs} : '0);
        rsh   = {acc, q[WIDTH-1]};
        rdiff = rsh - {1'b0, dvs};
        qbit  = ~rdiff[WIDTH];   // no borrow -> divisor fits
        if (is_div) begin
            acc_n = qbit ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], qbit};
        end else begin
            acc_n = msum[WIDTH:1];
            q_n   = {msum[0], q[WIDTH-1:1]};
        end
        prod = {acc_n, q_n};
        if (neg_q) prod = -prod;
        quo  = neg_q ? -q_n : q_n;
        rem  = neg_r ? -acc_n : acc_n;
        if (!is_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            dvs    <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // start beats a simultaneous mthi/mtlo
                        acc    <= '0;
                        q      <= abs_a;
                        dvs    <= abs_b;
                        a_raw  <= bus.srca;
                        is_div <= bus.op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        dz     <= (bus.srcb == '0);
                        if (fz) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            hi_r   <= fz_hi;
                            lo_r   <= fz_lo;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                            cnt    <= CW'(WIDTH - 1);
                        end
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        if (bus.mthi) hi_r <= bus.srca;
                        if (bus.mtlo) lo_r <= bus.srca;
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    if (cnt == '0) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
